// File: rtl/imem_loader_pkg.sv
// Shared types, constants and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader states; DONE is the only state in which the core is released.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR_HI  = 3'd1,
    HDR_LO  = 3'd2,
    DATA_HI = 3'd3,
    DATA_LO = 3'd4,
    CHK     = 3'd5,
    DONE    = 3'd6,
    ERR     = 3'd7
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 2;
  localparam int COUNT_W    = 8 * HDR_BYTES;
  localparam int WORD_W     = 8 * WORD_BYTES;

  // True for the states in which a stream byte may be accepted.
  function automatic logic accepts_bytes(input state_t s);
    logic r;
    case (s)
      HDR_HI, HDR_LO, DATA_HI, DATA_LO, CHK: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

  // Running frame checksum: plain XOR of every accepted byte.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte stream in, instruction-memory write port out.
// Modports are named from the stream's point of view: the byte source is the
// master, the loader is the slave (and it drives the memory write port).
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [15:0]       im_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Collects hi/lo stream bytes into a 16-bit word with a registered valid pulse
// and keeps the running XOR checksum of the frame.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              acc_en,
  input  logic              hi_en,
  input  logic              lo_en,
  input  logic [7:0]        data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid,
  output logic [7:0]        chk
);

  logic [7:0]        hi_q, hi_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [7:0]        chk_q, chk_d;

  // Next-state for the byte latches, the word pulse and the checksum.
  always_comb begin
    hi_d         = hi_q;
    word_d       = word_q;
    word_valid_d = lo_en;
    chk_d        = chk_q;
    if (hi_en) begin
      hi_d = data;
    end else begin
      hi_d = hi_q;
    end
    if (lo_en) begin
      word_d = {hi_q, data};
    end else begin
      word_d = word_q;
    end
    if (clr) begin
      chk_d = 8'h00;
    end else if (acc_en) begin
      chk_d = chk_update(chk_q, data);
    end else begin
      chk_d = chk_q;
    end
  end

  // Register the assembler state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q         <= 8'h00;
      word_q       <= {WORD_W{1'b0}};
      word_valid_q <= 1'b0;
      chk_q        <= 8'h00;
    end else begin
      hi_q         <= hi_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      chk_q        <= chk_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign chk        = chk_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a framed byte stream (count, words, XOR checksum),
// writes the words into instruction memory and releases the core only after
// a load that ends with a matching checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR_W:0] words_loaded
);

  localparam int               CNT_EXT_W = COUNT_W + 1;
  // Largest legal word count: the whole instruction memory.
  localparam logic [CNT_EXT_W-1:0] MAX_WORDS = CNT_EXT_W'(1) << ADDR_W;

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic [7:0]          hdr_hi_q, hdr_hi_d;

  logic                xfer;
  logic                asm_clr;
  logic                asm_acc;
  logic                asm_hi;
  logic                asm_lo;
  logic [WORD_W-1:0]   asm_word;
  logic                asm_word_valid;
  logic [7:0]          asm_chk;

  // in_ready is a flop, so a byte moves only on an edge where it was already high.
  assign xfer = bus.in_valid & in_ready_q;

  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .acc_en     (asm_acc),
    .hi_en      (asm_hi),
    .lo_en      (asm_lo),
    .data       (bus.in_data),
    .word       (asm_word),
    .word_valid (asm_word_valid),
    .chk        (asm_chk)
  );

  // Frame FSM: next state, counters, status flags and assembler controls.
  always_comb begin
    state_d        = state_q;
    hdr_hi_d       = hdr_hi_q;
    count_d        = count_q;
    index_d        = index_q;
    im_addr_d      = im_addr_q;
    done_d         = done_q;
    err_d          = err_q;
    words_loaded_d = words_loaded_q;
    asm_clr        = 1'b0;
    asm_hi         = 1'b0;
    asm_lo         = 1'b0;
    // The checksum byte itself is never folded into the checksum.
    asm_acc        = xfer & (state_q != CHK);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d        = HDR_HI;
          done_d         = 1'b0;
          err_d          = 1'b0;
          words_loaded_d = {(ADDR_W+1){1'b0}};
          index_d        = {ADDR_W{1'b0}};
          asm_clr        = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      HDR_HI: begin
        if (xfer) begin
          hdr_hi_d = bus.in_data;
          state_d  = HDR_LO;
        end else begin
          state_d = state_q;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          count_d = {hdr_hi_q, bus.in_data};
          if ({1'b0, count_d} > MAX_WORDS) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (count_d == {COUNT_W{1'b0}}) begin
            state_d = CHK;
          end else begin
            state_d = DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      DATA_HI: begin
        if (xfer) begin
          asm_hi  = 1'b1;
          state_d = DATA_LO;
        end else begin
          state_d = state_q;
        end
      end
      DATA_LO: begin
        if (xfer) begin
          asm_lo         = 1'b1;
          im_addr_d      = BASE_ADDR + index_q;
          index_d        = index_q + ADDR_W'(1'b1);
          words_loaded_d = words_loaded_q + (ADDR_W+1)'(1'b1);
          if (CNT_EXT_W'(words_loaded_q) + CNT_EXT_W'(1'b1) == {1'b0, count_q}) begin
            state_d = CHK;
          end else begin
            state_d = DATA_HI;
          end
        end else begin
          state_d = state_q;
        end
      end
      CHK: begin
        if (xfer) begin
          if (bus.in_data == asm_chk) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = accepts_bytes(state_d);
    cpu_hold_d = (state_d != DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      in_ready_q     <= 1'b0;
      im_addr_q      <= BASE_ADDR;
      cpu_hold_q     <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      words_loaded_q <= {(ADDR_W+1){1'b0}};
      index_q        <= {ADDR_W{1'b0}};
      count_q        <= {COUNT_W{1'b0}};
      hdr_hi_q       <= 8'h00;
    end else begin
      state_q        <= state_d;
      in_ready_q     <= in_ready_d;
      im_addr_q      <= im_addr_d;
      cpu_hold_q     <= cpu_hold_d;
      done_q         <= done_d;
      err_q          <= err_d;
      words_loaded_q <= words_loaded_d;
      index_q        <= index_d;
      count_q        <= count_d;
      hdr_hi_q       <= hdr_hi_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.im_we     = asm_word_valid;
  assign bus.im_addr   = im_addr_q;
  assign bus.im_wdata  = asm_word;
  assign cpu_hold      = cpu_hold_q;
  assign done          = done_q;
  assign err           = err_q;
  assign words_loaded  = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of fixed frames, hand-written
// corner sequences and randomized frames against a frame-level model.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_W(AW)) bus ();

  imem_loader #(.ADDR_W(AW), .BASE_ADDR(10'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  typedef struct {
    logic [15:0] hdr;
    logic [15:0] w0, w1, w2;
    logic [7:0]  flip;
    logic        exp_done;
    logic        exp_err;
    logic [AW:0] exp_wl;
  } vec_t;

  wr_t         act_q[$];
  wr_t         exp_q[$];
  logic [15:0] mem [0:1023];
  logic [15:0] wbuf [0:1023];
  int          rd_idx = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  vec_t        vt [7];

  // Memory-port monitor: records every write the loader performs.
  always @(negedge clk) begin
    wr_t w;
    if (bus.im_we === 1'b1) begin
      w.addr = bus.im_addr;
      w.data = bus.im_wdata;
      act_q.push_back(w);
      mem[bus.im_addr] <= bus.im_wdata;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until an edge with in_ready high takes it.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 20) break;
    end
    if (n > 20) begin
      n_cmp++;
      n_fail++;
      $display("FAIL ready_timeout: in_ready low for %0d cycles, expected high", n);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Frame model: header, words from wbuf, then XOR of all earlier bytes (^flip).
  task automatic run_frame(input logic [15:0] hdr, input logic [7:0] flip, input int maxgap);
    logic [7:0] sum;
    wr_t        e;
    sum   = 8'h00;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(hdr[15:8], int'($urandom_range(0, maxgap)));
    sum ^= hdr[15:8];
    send_byte(hdr[7:0], int'($urandom_range(0, maxgap)));
    sum ^= hdr[7:0];
    if (hdr <= 16'd1024) begin
      for (int i = 0; i < int'(hdr); i++) begin
        send_byte(wbuf[i][15:8], int'($urandom_range(0, maxgap)));
        send_byte(wbuf[i][7:0], int'($urandom_range(0, maxgap)));
        sum ^= wbuf[i][15:8];
        sum ^= wbuf[i][7:0];
        e.addr = i[AW-1:0];
        e.data = wbuf[i];
        exp_q.push_back(e);
      end
      send_byte(sum ^ flip, int'($urandom_range(0, maxgap)));
    end
  endtask

  task automatic compare_writes(input string tag);
    int na;
    int ne;
    na = act_q.size() - rd_idx;
    ne = exp_q.size();
    check({tag, "_wr_count"}, na, ne);
    for (int i = 0; i < na && i < ne; i++) begin
      check($sformatf("%s_wr%0d_addr", tag, i), act_q[rd_idx + i].addr, exp_q[i].addr);
      check($sformatf("%s_wr%0d_data", tag, i), act_q[rd_idx + i].data, exp_q[i].data);
    end
    rd_idx = act_q.size();
    exp_q.delete();
  endtask

  task automatic check_frame(input string tag, input logic exp_done, input logic exp_err,
                             input logic [AW:0] exp_wl);
    @(negedge clk);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_cpu_hold"}, cpu_hold, !exp_done);
    check({tag, "_in_ready"}, bus.in_ready, 1'b0);
    check({tag, "_words_loaded"}, words_loaded, exp_wl);
    tick();
    compare_writes(tag);
  endtask

  initial begin
    int          n;
    logic [7:0]  flip;

    vt[0] = '{16'h0002, 16'h1234, 16'hABCD, 16'h0000, 8'h00, 1'b1, 1'b0, 11'd2};
    vt[1] = '{16'h0002, 16'h1234, 16'hABCD, 16'h0000, 8'h01, 1'b0, 1'b1, 11'd2};
    vt[2] = '{16'h0002, 16'hCAFE, 16'h0001, 16'h0000, 8'h00, 1'b1, 1'b0, 11'd2};
    vt[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 11'd0};
    vt[4] = '{16'h0401, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b0, 1'b1, 11'd0};
    vt[5] = '{16'h0003, 16'h8001, 16'h7FFE, 16'hFFFF, 8'h80, 1'b0, 1'b1, 11'd3};
    vt[6] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 8'h00, 1'b1, 1'b0, 11'd1};

    rst          = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_im_we", bus.im_we, 1'b0);
    check("rst_im_addr", bus.im_addr, 10'd0);
    check("rst_im_wdata", bus.im_wdata, 16'h0000);
    check("rst_cpu_hold", cpu_hold, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_words_loaded", words_loaded, 11'd0);
    tick();
    rst = 1'b0;

    // Bytes offered while IDLE must not be taken.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("idle_in_ready%0d", i), bus.in_ready, 1'b0);
    end
    tick();
    bus.in_valid = 1'b0;

    // Fixed frames from the table.
    for (int v = 0; v < 7; v++) begin
      wbuf[0] = vt[v].w0;
      wbuf[1] = vt[v].w1;
      wbuf[2] = vt[v].w2;
      run_frame(vt[v].hdr, vt[v].flip, 2);
      check_frame($sformatf("vec%0d", v), vt[v].exp_done, vt[v].exp_err, vt[v].exp_wl);
    end

    // start pulsed while waiting in DATA_HI is ignored.
    begin
      wr_t e;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_byte(8'h00, 1);
      send_byte(8'h02, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      send_byte(8'h11, 1);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      send_byte(8'h22, 0);
      send_byte(8'h02 ^ 8'h11 ^ 8'h11 ^ 8'h22 ^ 8'h22, 0);
      e.addr = 10'd0; e.data = 16'h1111; exp_q.push_back(e);
      e.addr = 10'd1; e.data = 16'h2222; exp_q.push_back(e);
      check_frame("mid_start", 1'b1, 1'b0, 11'd2);
    end

    // Reset after the first data word has been written.
    begin
      wr_t e;
      start = 1'b1;
      tick();
      start = 1'b0;
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_byte(8'h5A, 0);
      send_byte(8'hA5, 0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_in_ready", bus.in_ready, 1'b0);
      check("mid_rst_im_we", bus.im_we, 1'b0);
      check("mid_rst_cpu_hold", cpu_hold, 1'b1);
      check("mid_rst_words_loaded", words_loaded, 11'd0);
      check("mid_rst_done", done, 1'b0);
      tick();
      check("mid_rst_mem0", mem[0], 16'h5AA5);
      e.addr = 10'd0; e.data = 16'h5AA5; exp_q.push_back(e);
      compare_writes("mid_rst");
    end

    // start and a valid byte in the same IDLE cycle: the byte is not consumed.
    start        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h03;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    begin
      wr_t e;
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h0B, 0);
      send_byte(8'hAD, 0);
      send_byte(8'h01 ^ 8'h0B ^ 8'hAD, 0);
      e.addr = 10'd0; e.data = 16'h0BAD; exp_q.push_back(e);
      check_frame("start_valid_idle", 1'b1, 1'b0, 11'd1);
    end

    // Randomized frames.
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) wbuf[i] = 16'($urandom);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      run_frame(16'(n), flip, 2);
      check_frame($sformatf("rand%0d", r), flip == 8'h00, flip != 8'h00, (AW+1)'(n));
    end

    // Full-memory frame: last write lands at 0x3FF, no extra write on wrap.
    for (int i = 0; i < 1024; i++) wbuf[i] = 16'($urandom);
    run_frame(16'h0400, 8'h00, 0);
    check_frame("full", 1'b1, 1'b0, 11'd1024);
    check("full_last_addr", bus.im_addr, 10'h3FF);
    repeat (5) tick();
    compare_writes("full_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
